// File: rtl/mul_sat_sequencer.sv
// Sequential signed WIDTHxWIDTH shift-and-add multiplier with saturation to WIDTH bits.
// One operation takes exactly WIDTH RUN cycles and is followed by a one-cycle done pulse.
module mul_sat_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Ovfl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     POS_SAT   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     NEG_SAT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0]   POS_LIM   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0]   NEG_LIM   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Returns {ovfl, result} for a signed magnitude product.
  function automatic logic [WIDTH:0] saturate(input logic neg, input logic [2*WIDTH-1:0] mag);
    logic [WIDTH:0] r;
    if (!neg) begin
      if (mag > POS_LIM) begin
        r = {1'b1, POS_SAT};
      end else begin
        r = {1'b0, mag[WIDTH-1:0]};
      end
    end else begin
      if (mag > NEG_LIM) begin
        r = {1'b1, NEG_SAT};
      end else begin
        r = {1'b0, ~mag[WIDTH-1:0] + ONE};
      end
    end
    return r;
  endfunction

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 sign_r;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [WIDTH:0]       sat_s;

  // Next accumulator value and the saturated view of it for the final iteration.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    sat_s = saturate(sign_r, acc_next_s);
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      Ovfl     <= 1'b0;
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      sign_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sign_r   <= A[WIDTH-1] ^ B[WIDTH-1];
            mcand_r  <= {{WIDTH{1'b0}}, abs_val(A)};
            mplier_r <= abs_val(B);
            acc_r    <= '0;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            Result  <= sat_s[WIDTH-1:0];
            Ovfl    <= sat_s[WIDTH];
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sat_sequencer.sv
// Self-checking bench for mul_sat_sequencer: vector table plus a result scoreboard
// and hand-written sequences for ignored start, back-to-back and mid-operation reset.
module tb_mul_sat_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] Result;
  logic        Ovfl;

  mul_sat_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .Ovfl(Ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovfl;
  } vec_t;

  vec_t        vecs[13];
  logic [16:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: exact integer product, then saturate.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    int p;
    logic [31:0] pv;
    p = int'($signed(a)) * int'($signed(b));
    pv = p;
    if (p > 32767) return {1'b1, 16'h7FFF};
    else if (p < -32768) return {1'b1, 16'h8000};
    else return {1'b0, pv[15:0]};
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eo);
    A = a;
    B = b;
    start = 1'b1;
    sb_q.push_back({eo, er});
    step();
    start = 1'b0;
  endtask

  // Called just after the edge that sampled start; spur >= 0 pulses start mid-run.
  task automatic await_done(input string name, input int spur);
    logic [15:0] prev;
    logic [16:0] e;
    bit          hold_ok;
    int          cyc;
    prev = Result;
    hold_ok = 1'b1;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == spur) begin
        start = 1'b1;
        A = 16'h1234;
        B = 16'h1234;
      end else begin
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
      end
      step();
      cyc++;
      if (!done && Result !== prev) hold_ok = 1'b0;
    end
    start = 1'b0;
    chk({name, "_latency"}, cyc, 32'd16);
    chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({name, "_hold"}, {31'd0, hold_ok}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_result"}, {16'd0, Result}, {16'd0, e[15:0]});
      chk({name, "_ovfl"}, {31'd0, Ovfl}, {31'd0, e[16]});
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [16:0] m;
    bit          quiet;

    vecs[0]  = '{16'h0003, 16'hFFFB, 16'hFFF1, 1'b0};
    vecs[1]  = '{16'h0100, 16'h0100, 16'h7FFF, 1'b1};
    vecs[2]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
    vecs[3]  = '{16'h8000, 16'h0001, 16'h8000, 1'b0};
    vecs[4]  = '{16'h4000, 16'hFFFD, 16'h8000, 1'b1};
    vecs[5]  = '{16'h0000, 16'h8000, 16'h0000, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'h8000, 16'h7FFF, 1'b1};
    vecs[8]  = '{16'h00B5, 16'h00B5, 16'h7FF9, 1'b0};
    vecs[9]  = '{16'h00B6, 16'h00B6, 16'h7FFF, 1'b1};
    vecs[10] = '{16'hFF80, 16'h0100, 16'h8000, 1'b0};
    vecs[11] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b0};
    vecs[12] = '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, Result}, 32'd0);
    chk("rst_ovfl", {31'd0, Ovfl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovfl);
      await_done($sformatf("vec%0d", i), -1);
      step();
    end

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = (i < 3) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      m = model(ra, rb);
      launch(ra, rb, m[15:0], m[16]);
      await_done($sformatf("rnd%0d", i), -1);
      step();
    end

    // start pulsed at cycle 5 of the run must be ignored
    launch(16'h0007, 16'h0006, 16'h002A, 1'b0);
    await_done("ign", 4);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy || done) quiet = 1'b0;
    end
    chk("ign_no_second_op", {31'd0, quiet}, 32'd1);

    // back-to-back: start held during the DONE cycle
    launch(16'h0003, 16'hFFFB, 16'hFFF1, 1'b0);
    await_done("pre_b2b", -1);
    A = 16'hFFFF;
    B = 16'hFFFF;
    start = 1'b1;
    sb_q.push_back({1'b0, 16'h0001});
    step();
    start = 1'b0;
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    chk("b2b_prev_hold", {16'd0, Result}, 32'h0000FFF1);
    await_done("b2b", -1);
    step();

    // reset mid-operation
    A = 16'h0003;
    B = 16'hFFFB;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", {16'd0, Result}, 32'd0);
    chk("arst_ovfl", {31'd0, Ovfl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy || done) quiet = 1'b0;
    end
    chk("arst_no_done", {31'd0, quiet}, 32'd1);

    launch(16'h0003, 16'hFFFB, 16'hFFF1, 1'b0);
    await_done("post_rst", -1);
    step();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
